keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Sequencing controller for the 4-row x 3-column phone keypad used by the clock's time-set entry. It drives one row at a time, samples the three column lines and debounces both press and release. For each accepted press it emits one registered 4-bit key code with a single-cycle valid strobe. It sits between the physical keypad lines and the clock's time-entry logic.

Parameters:
SCAN_DIV, 16, clocks each row is driven before its columns are evaluated (>=3).
DEBOUNCE_CYCLES, 1000, consecutive stable samples required to accept a press or a release (>=2).
CNT_W, 16, width of the dwell/debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CYCLES).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  asynchronous, active-high reset.
scan_en  input  1  1 = scanning runs; 0 = controller parks in SCAN and any press in progress is discarded.
cols  input  3  raw column lines, active-high, asynchronous; cols[2]=left, cols[1]=middle, cols[0]=right.
rows  output  4  one-hot row drive, active-high; rows[0]=top row (1 2 3), rows[3]=bottom row (* 0 #).
key_code  output  4  code of last accepted key: 0-9 = digits, 4'hA = '*', 4'hB = '#'.
key_valid  output  1  one-cycle strobe when key_code is updated.
key_held  output  1  high while an accepted key remains pressed.

Behaviour:
- Reset (async assert, sync release): rows=4'b0001, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters=0, synchroniser flops=0.
- cols pass through a 2-flop synchroniser; all decisions use the synchronised value (scols). Input-to-decision latency: 2 cycles.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Drive the current row and count dwell cycles from 0 to SCAN_DIV-1.
  - On the last dwell cycle, evaluate scols:
    - Exactly one bit set: latch row index and column, go to DEBOUNCE with rows frozen.
    - Zero bits or more than one bit set (ghosting/multi-press): advance to the next row, 3 wraps to 0, and restart the dwell count.
  - scan_en=0: dwell count holds and rows hold.
- DEBOUNCE:
  - Each cycle, compare scols with the latched one-hot column.
  - Equal: increment the counter.
  - Not equal: clear the counter and go to SCAN on the next row.
  - Counter reaching DEBOUNCE_CYCLES-1 with a match: next cycle key_code = map(row, col), key_valid=1 for exactly that cycle, key_held=1, state=HELD.
- Key map:
  - row0: 1,2,3
  - row1: 4,5,6
  - row2: 7,8,9
  - row3: A,0,B
  - Columns read left to right.
- HELD:
  - rows stay frozen and key_held=1.
  - Additional columns going high are ignored, so no second code is emitted.
  - scols==0 goes to RELEASE with the counter cleared.
- RELEASE:
  - scols==0: increment the counter.
  - Any nonzero scols: clear the counter and return to HELD.
  - Counter reaching DEBOUNCE_CYCLES-1: key_held=0, go to SCAN on the next row with the dwell count cleared.
- scan_en deasserted in DEBOUNCE, HELD or RELEASE: next cycle state=SCAN, key_held=0, no key_valid, rows hold the current row.
- key_code holds its value until the next accepted press; it is never cleared except by reset.
- key_valid never asserts on two consecutive cycles. Minimum spacing between strobes is 2*DEBOUNCE_CYCLES + SCAN_DIV cycles.
- Reset asserted in any state returns all outputs to reset values immediately.

Decomposition:
- Shared package keypad_pkg holds:
  - state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - NUM_ROWS=4 and NUM_COLS=3;
  - key code constants KEY_STAR=4'hA and KEY_HASH=4'hB;
  - the row/column-to-code lookup function.
- One sub-module, keypad_sync2: a 3-bit 2-flop synchroniser with async reset.
- FSM, counters and row rotation live in keypad_scan_ctrl.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
1. Idle after reset, cols=000, scan_en=1 -> rows cycle 0001,0010,0100,1000,0001, 4 clocks each; key_valid stays 0.
2. Hold cols=100 only while rows=0010, kept for 40 cycles then released -> exactly one key_valid with key_code=4; key_held=1 until 8 clean zero samples after release; scanning then resumes at rows=0100.
3. Press '#' (rows=1000, cols=001), then '0' (cols=010), sequentially with full release between -> key_code=4'hB, then 4'h0, one strobe each.
4. Bounce on press: for '8' (rows=0100, cols=010), cols toggle 010/000 every 3 cycles for 30 cycles, then stable -> no strobe during the bounce; exactly one strobe with code 8 after stabilising.
5. Multi-press: cols=110 on rows=0001 -> no strobe, and scanning continues. Second key added while HELD -> no additional strobe.
6. Reset or scan_en=0 mid-DEBOUNCE (counter at 5) -> no strobe. Reset: rows=0001, key_code=0. scan_en=0: state=SCAN, key_held=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, sizes and the row/column-to-code lookup used by the keypad
// scan controller and its bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // col is one-hot with bit 2 as the leftmost column.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [2:0] col);
        logic [3:0] pos;
        logic [3:0] code;
        case (col)
            3'b100:  pos = 4'd0;
            3'b010:  pos = 4'd1;
            default: pos = 4'd2;
        endcase
        if (row == 2'd3) begin
            case (pos)
                4'd0:    code = KEY_STAR;
                4'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + pos + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad line and key-event bundle between the scan controller (master) and
// the physical keypad / time-entry logic (slave).
interface keypad_scan_ctrl_if;

    // key_valid is a single-cycle strobe with no ready: the consumer must take
    // key_code in the cycle key_valid is high; key_code stays stable afterwards.
    logic                  scan_en;
    logic [2:0]            cols;
    logic [3:0]            rows;
    logic [3:0]            key_code;
    logic                  key_valid;
    logic                  key_held;
    keypad_pkg::state_t    state;

    modport master (
        input  scan_en,
        input  cols,
        output rows,
        output key_code,
        output key_valid,
        output key_held,
        output state
    );

    modport slave (
        output scan_en,
        output cols,
        input  rows,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  state
    );

endinterface

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
module keypad_sync2 #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: drives one row at a time, debounces press and
// release of a single key, and emits one key code strobe per accepted press.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset,
    keypad_scan_ctrl_if.master  kif
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] scols;

    keypad_sync2 #(.W(NUM_COLS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kif.cols),
        .q     (scols)
    );

    state_t            state_d, state_q;
    logic [1:0]        row_idx_d, row_idx_q;
    logic [3:0]        rows_d, rows_q;
    logic [2:0]        col_d, col_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [3:0]        key_code_d, key_code_q;
    logic              key_valid_d, key_valid_q;
    logic              key_held_d, key_held_q;

    logic              scols_onehot;

    assign scols_onehot = (scols == 3'b001) || (scols == 3'b010) || (scols == 3'b100);

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            SCAN: begin
                key_held_d = 1'b0;
                if (kif.scan_en) begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        // Zero or several columns (multi-press/ghosting) just move on.
                        if (scols_onehot) begin
                            col_d   = scols;
                            state_d = DEBOUNCE;
                        end else begin
                            row_idx_d = row_idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DEBOUNCE: begin
                if (!kif.scan_en) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else if (scols == col_q) begin
                    if (cnt_q == DB_LAST) begin
                        key_code_d  = key_map(row_idx_q, col_q);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = HELD;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d     = '0;
                    state_d   = SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                end
            end

            HELD: begin
                if (!kif.scan_en) begin
                    state_d    = SCAN;
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                end else if (scols == 3'b000) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end

            RELEASE: begin
                if (!kif.scan_en) begin
                    state_d    = SCAN;
                    key_held_d = 1'b0;
                    cnt_d      = '0;
                end else if (scols == 3'b000) begin
                    if (cnt_q == DB_LAST) begin
                        key_held_d = 1'b0;
                        state_d    = SCAN;
                        row_idx_d  = row_idx_q + 2'd1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = HELD;
                end
            end

            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        rows_d = 4'b0001 << row_idx_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            rows_q      <= 4'b0001;
            col_q       <= 3'b000;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            rows_q      <= rows_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kif.rows      = rows_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_held  = key_held_q;
    assign kif.state     = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a behavioural keypad drives the columns from the
// rows, expected key codes are queued at press time and popped on each strobe.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    logic clk;
    logic reset;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- keypad model ----------------
    // pressed[r*3 + p]: row r (0 = top), position p (0 = left .. 2 = right).
    logic [11:0] pressed;
    logic [2:0]  cols_model;
    logic [3:0]  code_tab [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                   4'd7, 4'd8, 4'd9, 4'hA, 4'd0, 4'hB};

    always_comb begin
        cols_model = 3'b000;
        for (int r = 0; r < 4; r++) begin
            if (kif.rows[r])
                cols_model = cols_model | {pressed[r*3], pressed[r*3+1], pressed[r*3+2]};
        end
    end
    assign kif.cols = cols_model;

    // ---------------- scoreboard ----------------
    int total;
    int bad;
    logic [3:0] exp_q[$];
    logic prev_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && kif.key_valid) begin
            check("strobe_spacing", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_strobe: got code %0h expected no strobe at %0t",
                         kif.key_code, $time);
            end else begin
                check("key_code", {28'd0, kif.key_code}, {28'd0, exp_q.pop_front()});
            end
        end
        prev_valid <= kif.key_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input state_t st, input int budget, input string name);
        int n;
        n = 0;
        while (kif.state !== st && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(kif.state), 32'(st));
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (kif.key_held !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, kif.key_held}, {31'd0, lvl});
    endtask

    task automatic press_and_release(input int k, input int hold, input int gap);
        exp_q.push_back(code_tab[k]);
        pressed[k] = 1'b1;
        tick(hold);
        check("held_while_pressed", {31'd0, kif.key_held}, 32'd1);
        pressed[k] = 1'b0;
        tick(gap);
        check("held_after_release", {31'd0, kif.key_held}, 32'd0);
        check("code_holds", {28'd0, kif.key_code}, {28'd0, code_tab[k]});
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] saved_rows;

    initial begin
        total      = 0;
        bad        = 0;
        prev_valid = 1'b0;
        pressed    = '0;
        kif.scan_en = 1'b1;
        reset      = 1'b1;
        #1;
        check("reset_rows", {28'd0, kif.rows}, 32'h1);
        check("reset_code", {28'd0, kif.key_code}, 32'h0);
        check("reset_valid", {31'd0, kif.key_valid}, 32'h0);
        check("reset_held", {31'd0, kif.key_held}, 32'h0);
        check("reset_state", 32'(kif.state), 32'(SCAN));
        @(negedge clk);
        reset = 1'b0;

        // Idle scanning: each row for 4 clocks, wrapping.
        for (int k = 0; k < 20; k++) begin
            check("idle_rows", {28'd0, kif.rows}, 32'(4'b0001 << ((k / 4) % 4)));
            tick(1);
        end

        // Key '4', then release: scanning resumes on the next row.
        exp_q.push_back(4'd4);
        pressed[3] = 1'b1;
        wait_held(1'b1, 60, "key4_held_rise");
        tick(40);
        pressed[3] = 1'b0;
        tick(8);
        check("key4_held_through_release", {31'd0, kif.key_held}, 32'd1);
        wait_held(1'b0, 8, "key4_held_fall");
        check("rows_after_release", {28'd0, kif.rows}, 32'b0100);
        tick(10);

        // '#' then '0'.
        press_and_release(11, 45, 20);
        press_and_release(10, 45, 20);

        // Bouncing '8': no strobe until the contact settles.
        for (int i = 0; i < 10; i++) begin
            pressed[7] = (i % 2 == 0);
            tick(3);
        end
        press_and_release(7, 50, 25);

        // Two keys on the top row together: ignored, scanning continues.
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        tick(40);
        check("multi_state", 32'(kif.state), 32'(SCAN));
        saved_rows = kif.rows;
        tick(4);
        check("multi_rows_advance", {31'd0, kif.rows != saved_rows}, 32'd1);
        pressed[0] = 1'b0;
        pressed[1] = 1'b0;
        tick(20);

        // Extra keys while '5' is held produce no second code.
        exp_q.push_back(4'd5);
        pressed[4] = 1'b1;
        wait_held(1'b1, 60, "key5_held_rise");
        tick(5);
        pressed[5] = 1'b1;
        pressed[0] = 1'b1;
        tick(30);
        check("key5_still_held", {31'd0, kif.key_held}, 32'd1);
        check("key5_state", 32'(kif.state), 32'(HELD));
        pressed[4] = 1'b0;
        pressed[5] = 1'b0;
        pressed[0] = 1'b0;
        tick(25);
        check("key5_released", {31'd0, kif.key_held}, 32'd0);

        // Randomised single-key presses.
        for (int n = 0; n < 10; n++) begin
            press_and_release($urandom_range(0, 11), $urandom_range(40, 70),
                              $urandom_range(16, 30));
        end

        // Reset in the middle of debounce.
        pressed[0] = 1'b1;
        wait_state(DEBOUNCE, 60, "reach_debounce_rst");
        tick(5);
        reset = 1'b1;
        #1;
        check("mid_rst_rows", {28'd0, kif.rows}, 32'h1);
        check("mid_rst_code", {28'd0, kif.key_code}, 32'h0);
        check("mid_rst_held", {31'd0, kif.key_held}, 32'h0);
        check("mid_rst_state", 32'(kif.state), 32'(SCAN));
        pressed[0] = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(10);

        // scan_en dropped in the middle of debounce.
        pressed[8] = 1'b1;
        wait_state(DEBOUNCE, 60, "reach_debounce_en");
        tick(5);
        kif.scan_en = 1'b0;
        saved_rows = kif.rows;
        tick(1);
        check("scan_off_state", 32'(kif.state), 32'(SCAN));
        check("scan_off_held", {31'd0, kif.key_held}, 32'd0);
        check("scan_off_rows", {28'd0, kif.rows}, {28'd0, saved_rows});
        tick(20);
        check("scan_off_rows_hold", {28'd0, kif.rows}, {28'd0, saved_rows});
        check("scan_off_code", {28'd0, kif.key_code}, 32'h0);
        pressed[8] = 1'b0;
        kif.scan_en = 1'b1;
        tick(20);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
